ucsbece154a_mc_controller: RTL and testbench

// - Parametrised multicycle RV32I control FSM. It is the successor controller with a wider ALU op set,
//   bne/jalr/xor/shift support, illegal-opcode fault trapping and an optional memory wait handshake.
// - It sits between the instruction register/ALU flags and the multicycle datapath.
// - It drives all datapath enables and muxes from a Moore decode of the current state register.

---
 rtl/ucsbece154a_mc_controller.sv | 223 ++++++++++++++++++++++
 tb/tb_ucsbece154a_mc_controller.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucsbece154a_mc_controller.sv
// Multicycle RV32I control FSM: Moore decode of the state register drives the datapath enables/muxes.
// Optional memory wait handshake with timeout is enabled by defining CTRL_MEM_HANDSHAKE_EN.
module ucsbece154a_mc_controller #(
    parameter int ALU_CTRL_W  = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int TIMEOUT_W   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [6:0]            op_i,
    input  logic [2:0]            funct3_i,
    input  logic                  funct7_i,
    input  logic                  zero_i,
    input  logic                  mem_ready_i,
    output logic                  PCWrite_o,
    output logic                  MemWrite_o,
    output logic                  IRWrite_o,
    output logic                  RegWrite_o,
    output logic                  AdrSrc_o,
    output logic [1:0]            ALUSrcA_o,
    output logic [1:0]            ALUSrcB_o,
    output logic [1:0]            ResultSrc_o,
    output logic [ALU_CTRL_W-1:0] ALUControl_o,
    output logic [2:0]            ImmSrc_o,
    output logic                  mem_req_o,
    output logic                  fault_o,
    output logic [1:0]            fault_cause_o,
    output logic [3:0]            state_dbg_o
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
        S_ALUWB, S_JAL, S_JALR, S_JALLINK, S_BRANCH, S_LUI, S_FAULT
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                           ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLL = 4'd6, ALU_SRL = 4'd7,
                           ALU_SRA = 4'd8, ALU_PASSB = 4'd9;

    state_t               r_state, w_state_next;
    logic [1:0]           r_fault_cause, w_cause_next;
    logic [TIMEOUT_W-1:0] r_wait_cnt;
    logic                 w_ready, w_timeout, w_mem_state;
    logic                 w_pc_update, w_branch, w_mem_write, w_ir_write, w_reg_write, w_adr_src;
    logic                 w_mem_req, w_fault;
    logic [1:0]           w_src_a, w_src_b, w_res_src;
    logic [3:0]           w_alu, w_funct_alu;

    // Memory handshake: a memory state (FETCH/MEMREAD/MEMWRITE) holds mem_req_o high and completes
    // in the cycle mem_ready_i is sampled high; that cycle alone carries IRWrite/PCUpdate/MemWrite.
`ifdef CTRL_MEM_HANDSHAKE_EN
    assign w_ready = mem_ready_i;
`else
    assign w_ready = 1'b1 | mem_ready_i;
`endif

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);
    assign w_timeout   = (r_wait_cnt == TIMEOUT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_FETCH;
            r_fault_cause <= 2'b00;
            r_wait_cnt    <= '0;
        end else begin
            r_state       <= w_state_next;
            r_fault_cause <= w_cause_next;
            if (w_mem_state && (w_state_next == r_state))
                r_wait_cnt <= r_wait_cnt + TIMEOUT_W'(1);
            else
                r_wait_cnt <= '0;
        end
    end

    always_comb begin
        case (funct3_i)
            3'b000:  w_funct_alu = (funct7_i & op_i[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  w_funct_alu = ALU_SLL;
            3'b010:  w_funct_alu = ALU_SLT;
            3'b100:  w_funct_alu = ALU_XOR;
            3'b101:  w_funct_alu = funct7_i ? ALU_SRA : ALU_SRL;
            3'b110:  w_funct_alu = ALU_OR;
            3'b111:  w_funct_alu = ALU_AND;
            default: w_funct_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_cause_next = r_fault_cause;
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_adr_src    = 1'b0;
        w_mem_req    = 1'b0;
        w_fault      = 1'b0;
        w_src_a      = 2'b00;
        w_src_b      = 2'b00;
        w_res_src    = 2'b00;
        w_alu        = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_ir_write  = w_ready;
                w_pc_update = w_ready;
                w_src_b     = 2'b10;
                w_res_src   = 2'b10;
                w_mem_req   = 1'b1;
                if (w_ready) w_state_next = S_DECODE;
                else if (w_timeout) begin
                    w_state_next = S_FAULT;
                    w_cause_next = 2'b10;
                end
            end
            S_DECODE: begin
                w_src_a = 2'b01;
                w_src_b = 2'b01;
                case (op_i)
                    7'b0000011, 7'b0100011: w_state_next = S_MEMADR;
                    7'b0110011: w_state_next = S_EXECR;
                    7'b0010011: w_state_next = S_EXECI;
                    7'b1100011: w_state_next = S_BRANCH;
                    7'b1101111: w_state_next = S_JAL;
                    7'b1100111: w_state_next = S_JALR;
                    7'b0110111: w_state_next = S_LUI;
                    default: begin
                        w_state_next = S_FAULT;
                        w_cause_next = 2'b01;
                    end
                endcase
            end
            S_MEMADR: begin
                w_src_a      = 2'b10;
                w_src_b      = 2'b01;
                w_state_next = (op_i == 7'b0100011) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD, S_MEMWRITE: begin
                w_adr_src   = 1'b1;
                w_mem_req   = 1'b1;
                w_mem_write = (r_state == S_MEMWRITE) && w_ready;
                if (w_ready) w_state_next = (r_state == S_MEMWRITE) ? S_FETCH : S_MEMWB;
                else if (w_timeout) begin
                    w_state_next = S_FAULT;
                    w_cause_next = 2'b10;
                end
            end
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                w_res_src    = 2'b01;
                w_state_next = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                w_src_a      = 2'b10;
                w_src_b      = (r_state == S_EXECI) ? 2'b01 : 2'b00;
                w_alu        = w_funct_alu;
                w_state_next = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write  = 1'b1;
                w_state_next = S_FETCH;
            end
            S_JAL: begin
                w_pc_update  = 1'b1;
                w_src_a      = 2'b01;
                w_src_b      = 2'b10;
                w_state_next = S_ALUWB;
            end
            S_JALR: begin
                w_pc_update  = 1'b1;
                w_res_src    = 2'b10;
                w_src_a      = 2'b10;
                w_src_b      = 2'b01;
                w_state_next = S_JALLINK;
            end
            S_JALLINK: begin
                w_src_a      = 2'b01;
                w_src_b      = 2'b10;
                w_state_next = S_ALUWB;
            end
            S_BRANCH: begin
                w_branch     = 1'b1;
                w_src_a      = 2'b10;
                w_alu        = ALU_SUB;
                w_state_next = S_FETCH;
            end
            S_LUI: begin
                w_src_b      = 2'b01;
                w_res_src    = 2'b10;
                w_alu        = ALU_PASSB;
                w_state_next = S_ALUWB;
            end
            S_FAULT: w_fault = 1'b1;
            default: w_state_next = S_FETCH;
        endcase
    end

    // funct3_i[0] separates beq (take on zero) from bne (take on not-zero)
    assign PCWrite_o  = reset_n & (w_pc_update | (w_branch & (zero_i ^ funct3_i[0])));
    assign MemWrite_o = reset_n & w_mem_write;
    assign IRWrite_o  = reset_n & w_ir_write;
    assign RegWrite_o = reset_n & w_reg_write;
    assign mem_req_o  = reset_n & w_mem_req;
    assign AdrSrc_o      = w_adr_src;
    assign ALUSrcA_o     = w_src_a;
    assign ALUSrcB_o     = w_src_b;
    assign ResultSrc_o   = w_res_src;
    assign ALUControl_o  = ALU_CTRL_W'(w_alu);
    assign fault_o       = w_fault;
    assign fault_cause_o = r_fault_cause;
    assign state_dbg_o   = r_state;

    always_comb begin
        case (op_i)
            7'b0100011: ImmSrc_o = 3'b001;
            7'b1100011: ImmSrc_o = 3'b010;
            7'b1101111: ImmSrc_o = 3'b011;
            7'b0110111: ImmSrc_o = 3'b100;
            default:    ImmSrc_o = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_ucsbece154a_mc_controller.sv
// Bench for ucsbece154a_mc_controller: per-instruction output sequences built from the instruction
// behaviour, checked every cycle, plus literal spot checks. Handshake cases depend on CTRL_MEM_HANDSHAKE_EN.
`timescale 1ns/1ps
module tb_ucsbece154a_mc_controller;

    localparam int OW          = 22;
    localparam int MEM_TIMEOUT = 15;
`ifdef CTRL_MEM_HANDSHAKE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif
    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111;

    typedef struct packed {
        logic       pcw, memw, irw, regw, adr;
        logic [1:0] srca, srcb, res;
        logic [3:0] alu;
        logic [2:0] imm;
        logic       memreq, fault;
        logic [1:0] cause;
    } ov_t;

    logic       clk, reset_n, funct7_i, zero_i, mem_ready_i;
    logic [6:0] op_i;
    logic [2:0] funct3_i, ImmSrc_o;
    logic       PCWrite_o, MemWrite_o, IRWrite_o, RegWrite_o, AdrSrc_o, mem_req_o, fault_o;
    logic [1:0] ALUSrcA_o, ALUSrcB_o, ResultSrc_o, fault_cause_o;
    logic [3:0] ALUControl_o, state_dbg_o;

    ucsbece154a_mc_controller dut (
        .clk(clk), .reset_n(reset_n), .op_i(op_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
        .zero_i(zero_i), .mem_ready_i(mem_ready_i), .PCWrite_o(PCWrite_o), .MemWrite_o(MemWrite_o),
        .IRWrite_o(IRWrite_o), .RegWrite_o(RegWrite_o), .AdrSrc_o(AdrSrc_o), .ALUSrcA_o(ALUSrcA_o),
        .ALUSrcB_o(ALUSrcB_o), .ResultSrc_o(ResultSrc_o), .ALUControl_o(ALUControl_o),
        .ImmSrc_o(ImmSrc_o), .mem_req_o(mem_req_o), .fault_o(fault_o),
        .fault_cause_o(fault_cause_o), .state_dbg_o(state_dbg_o)
    );

    ov_t act;
    assign act = {PCWrite_o, MemWrite_o, IRWrite_o, RegWrite_o, AdrSrc_o, ALUSrcA_o, ALUSrcB_o,
                  ResultSrc_o, ALUControl_o, ImmSrc_o, mem_req_o, fault_o, fault_cause_o};

    logic [OW-1:0] exp_q[$];
    logic          rdy_q[$];
    ov_t           obs[$];
    logic [OW-1:0] exp_v;
    int            n_checks = 0;
    int            n_fail = 0;
    string         cur_name = "reset";

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    // scoreboard: one expected vector per cycle while an instruction is running
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            obs.push_back(act);
            n_checks++;
            if (act !== exp_v) begin
                n_fail++;
                $display("FAIL %s cycle %0d: actual %h required %h", cur_name, obs.size() - 1, act, exp_v);
            end
        end
    end

    task automatic check(input string name, input int act_v, input int exp_i);
        n_checks++;
        if (act_v != exp_i) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act_v, exp_i);
        end
    endtask

    // behavioural model
    function automatic logic [2:0] imm_of(input logic [6:0] op);
        if (op == OP_SW) return 3'd1;
        if (op == OP_BR) return 3'd2;
        if (op == OP_JAL) return 3'd3;
        if (op == OP_LUI) return 3'd4;
        return 3'd0;
    endfunction

    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic f7, input logic is_r);
        case (f3)
            3'd0: return (f7 && is_r) ? 4'd1 : 4'd0;
            3'd1: return 4'd6;
            3'd2: return 4'd5;
            3'd4: return 4'd4;
            3'd5: return f7 ? 4'd8 : 4'd7;
            3'd6: return 4'd3;
            3'd7: return 4'd2;
            default: return 4'd0;
        endcase
    endfunction

    function automatic ov_t base(input logic [6:0] op);
        ov_t v;
        v = '0;
        v.imm = imm_of(op);
        return v;
    endfunction

    task automatic push(input ov_t v, input logic r);
        exp_q.push_back(v);
        rdy_q.push_back(r);
    endtask

    task automatic push_fault(input logic [6:0] op, input logic [1:0] c, input int n);
        ov_t v;
        v = base(op);
        v.fault = 1'b1;
        v.cause = c;
        for (int i = 0; i < n; i++) push(v, 1'b1);
    endtask

    task automatic wait_cycles(input ov_t wv, input int n, input logic [6:0] op, output bit to);
        to = 1'b0;
        for (int i = 0; i < n && i < MEM_TIMEOUT; i++) push(wv, 1'b0);
        if (n >= MEM_TIMEOUT) begin
            push_fault(op, 2'b10, 3);
            to = 1'b1;
        end
    endtask

    task automatic alu_wb(input logic [6:0] op);
        ov_t v;
        v = base(op);
        v.regw = 1'b1;
        push(v, HS);
    endtask

    task automatic model_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                               input logic z, input int fw, input int mw);
        ov_t v;
        bit  to;
        v = base(op); v.memreq = 1; v.srcb = 2; v.res = 2;
        wait_cycles(v, HS ? fw : 0, op, to);
        if (to) return;
        v.irw = 1; v.pcw = 1; push(v, HS);
        v = base(op); v.srca = 1; v.srcb = 1; push(v, HS);
        case (op)
            OP_LW, OP_SW: begin
                v = base(op); v.srca = 2; v.srcb = 1; push(v, HS);
                v = base(op); v.adr = 1; v.memreq = 1;
                wait_cycles(v, HS ? mw : 0, op, to);
                if (to) return;
                if (op == OP_SW) begin
                    v.memw = 1; push(v, HS);
                end else begin
                    push(v, HS);
                    v = base(op); v.regw = 1; v.res = 1; push(v, HS);
                end
            end
            OP_R, OP_I: begin
                v = base(op); v.srca = 2; v.srcb = (op == OP_R) ? 2'd0 : 2'd1;
                v.alu = alu_of(f3, f7, op == OP_R); push(v, HS);
                alu_wb(op);
            end
            OP_BR: begin
                v = base(op); v.srca = 2; v.alu = 1; v.pcw = z ^ f3[0]; push(v, HS);
            end
            OP_JAL: begin
                v = base(op); v.pcw = 1; v.srca = 1; v.srcb = 2; push(v, HS);
                alu_wb(op);
            end
            OP_JALR: begin
                v = base(op); v.pcw = 1; v.res = 2; v.srca = 2; v.srcb = 1; push(v, HS);
                v = base(op); v.srca = 1; v.srcb = 2; push(v, HS);
                alu_wb(op);
            end
            OP_LUI: begin
                v = base(op); v.srcb = 1; v.res = 2; v.alu = 9; push(v, HS);
                alu_wb(op);
            end
            default: push_fault(op, 2'b01, 4);
        endcase
    endtask

    // driver: called at posedge+1 while the DUT sits in FETCH
    task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic z, input int fw, input int mw,
                             input int stop);
        int n;
        cur_name = name;
        obs.delete();
        model_instr(op, f3, f7, z, fw, mw);
        if (stop >= 0)
            while (exp_q.size() > stop) begin
                void'(exp_q.pop_back());
                void'(rdy_q.pop_back());
            end
        op_i = op; funct3_i = f3; funct7_i = f7; zero_i = z;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            mem_ready_i = rdy_q.pop_front();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_pulse(input string name);
        reset_n = 1'b0;
        #1;
        check({name, "_enables"}, {PCWrite_o, MemWrite_o, IRWrite_o, RegWrite_o, mem_req_o}, 0);
        check({name, "_fault"}, fault_o, 0);
        check({name, "_cause"}, fault_cause_o, 0);
        check({name, "_fetch_srcb"}, ALUSrcB_o, 2);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    int c;
    initial begin
        reset_n = 1'b0; op_i = '0; funct3_i = '0; funct7_i = 1'b0; zero_i = 1'b0; mem_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_enables", {PCWrite_o, MemWrite_o, IRWrite_o, RegWrite_o, mem_req_o}, 0);
        check("rst_cause", fault_cause_o, 0);
        check("rst_fault", fault_o, 0);
        reset_n = 1'b1;

        run_instr("add", OP_R, 3'd0, 1'b0, 1'b0, 0, 0, -1);
        check("add_alu", obs[2].alu, 0);
        check("add_regw_c4", obs[3].regw, 1);
        c = 0;
        foreach (obs[k]) c += obs[k].regw;
        check("add_regw_once", c, 1);
        run_instr("sub", OP_R, 3'd0, 1'b1, 1'b0, 0, 0, -1);
        check("sub_alu", obs[2].alu, 1);
        run_instr("xor", OP_R, 3'd4, 1'b0, 1'b0, 0, 0, -1);
        run_instr("sra", OP_R, 3'd5, 1'b1, 1'b0, 0, 0, -1);
        run_instr("slt", OP_R, 3'd2, 1'b0, 1'b0, 0, 0, -1);
        run_instr("addi_f7", OP_I, 3'd0, 1'b1, 1'b0, 0, 0, -1);
        check("addi_f7_alu", obs[2].alu, 0);
        run_instr("srai", OP_I, 3'd5, 1'b1, 1'b0, 0, 0, -1);
        check("srai_alu", obs[2].alu, 8);
        run_instr("srli", OP_I, 3'd5, 1'b0, 1'b0, 0, 0, -1);
        check("srli_alu", obs[2].alu, 7);
        run_instr("slli", OP_I, 3'd1, 1'b0, 1'b0, 0, 0, -1);
        run_instr("ori", OP_I, 3'd6, 1'b0, 1'b0, 0, 0, -1);
        run_instr("andi", OP_I, 3'd7, 1'b0, 1'b0, 0, 0, -1);
        run_instr("beq_z1", OP_BR, 3'd0, 1'b0, 1'b1, 0, 0, -1);
        check("beq_z1_pcw", obs[2].pcw, 1);
        run_instr("beq_z0", OP_BR, 3'd0, 1'b0, 1'b0, 0, 0, -1);
        check("beq_z0_pcw", obs[2].pcw, 0);
        run_instr("bne_z0", OP_BR, 3'd1, 1'b0, 1'b0, 0, 0, -1);
        check("bne_z0_pcw", obs[2].pcw, 1);
        check("bne_imm", obs[0].imm, 2);
        run_instr("bne_z1", OP_BR, 3'd1, 1'b0, 1'b1, 0, 0, -1);
        check("bne_z1_pcw", obs[2].pcw, 0);
        run_instr("jal", OP_JAL, 3'd0, 1'b0, 1'b0, 0, 0, -1);
        check("jal_imm", obs[0].imm, 3);
        run_instr("jalr", OP_JALR, 3'd0, 1'b0, 1'b0, 0, 0, -1);
        check("jalr_pcw", obs[2].pcw, 1);
        check("jalr_res", obs[2].res, 2);
        check("jallink_src", {obs[3].srca, obs[3].srcb}, 4'b0110);
        check("jalr_regw_c5", obs[4].regw, 1);
        run_instr("lui", OP_LUI, 3'd0, 1'b0, 1'b0, 0, 0, -1);
        check("lui_alu", obs[2].alu, 9);
        run_instr("lw", OP_LW, 3'd2, 1'b0, 1'b0, 0, 0, -1);
        check("lw_regw_c5", obs[4].regw, 1);
        run_instr("sw", OP_SW, 3'd2, 1'b0, 1'b0, 0, 0, -1);
        check("sw_memw", obs[3].memw, 1);

        run_instr("lw_abort", OP_LW, 3'd2, 1'b0, 1'b0, 0, 0, 2);
        reset_pulse("mid_lw_reset");
        run_instr("illegal", 7'b0000000, 3'd0, 1'b0, 1'b0, 0, 0, -1);
        check("illegal_fault", obs[2].fault, 1);
        check("illegal_cause", obs[2].cause, 1);
        check("illegal_quiet", {obs[4].pcw, obs[4].irw, obs[4].regw, obs[4].memreq}, 0);
        reset_pulse("fault_reset");

        run_instr("lw_wait3", OP_LW, 3'd2, 1'b0, 1'b0, 0, 3, -1);
        check("lw_wait3_wb", obs[HS ? 7 : 4].regw, 1);
        run_instr("sw_waits", OP_SW, 3'd2, 1'b0, 1'b0, 2, 2, -1);
        run_instr("lw_wait10", OP_LW, 3'd2, 1'b0, 1'b0, 10, 10, -1);
        run_instr("lw_ready_wins", OP_LW, 3'd2, 1'b0, 1'b0, 0, 14, -1);
        check("ready_wins_wb", obs[HS ? 18 : 4].regw, 1);
        run_instr("fetch_timeout", OP_R, 3'd0, 1'b0, 1'b0, 15, 0, -1);
        c = 0;
        foreach (obs[k]) c += obs[k].irw;
        check("timeout_irw", c, HS ? 0 : 1);
        check("timeout_fault", obs[obs.size() - 1].fault, HS ? 1 : 0);
        check("timeout_cause", obs[obs.size() - 1].cause, HS ? 2 : 0);
        reset_pulse("timeout_reset");
        run_instr("add_after", OP_R, 3'd0, 1'b0, 1'b0, 0, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
